// File: rtl/operand_fetch_stage_if.sv
// Bundle of all operand-fetch stage signals except clock and reset.
// The slave modport is the stage's view; the master modport is the environment's view.
// The environment drives the instruction, register-file data, write-back and EX-side ready.
interface operand_fetch_stage_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  // instruction handshake
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  // register file read ports (data is combinational from address)
  logic [AW-1:0] reg_read_addr_1;
  logic [DW-1:0] reg_read_data_1;
  logic [AW-1:0] reg_read_addr_2;
  logic [DW-1:0] reg_read_data_2;
  // write-back snoop
  logic          wb_en;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  // ID/EX entry
  logic          flush;
  logic          ex_ready;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [AW-1:0] ex_rd;
  logic          ex_wr;
  logic [DW-1:0] ex_op1;
  logic [DW-1:0] ex_op2;
  logic [DW-1:0] ex_imm;

  modport slave (
    input  instr_valid, instr, reg_read_data_1, reg_read_data_2,
           wb_en, wb_dest, wb_data, flush, ex_ready,
    output instr_ready, reg_read_addr_1, reg_read_addr_2,
           ex_valid, ex_opcode, ex_rd, ex_wr, ex_op1, ex_op2, ex_imm
  );

  modport master (
    output instr_valid, instr, reg_read_data_1, reg_read_data_2,
           wb_en, wb_dest, wb_data, flush, ex_ready,
    input  instr_ready, reg_read_addr_1, reg_read_addr_2,
           ex_valid, ex_opcode, ex_rd, ex_wr, ex_op1, ex_op2, ex_imm
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: decodes, reads the register file, forwards write-back, fills ID/EX.
// Latency 1 cycle instruction -> ex entry; throughput 1/cycle when hazard free.
// Stalls on RAW/WAW against the busy scoreboard, on a held ex entry with !ex_ready, and on flush.
module operand_fetch_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input logic clk,
  input logic rst,
  operand_fetch_stage_if.slave bus
);
  localparam int AW = $clog2(NREG);

  // instruction fields
  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [5:0]    imm6;

  // decode / hazard signals
  logic          use_a, use_b, rd_as_src, wr_cls;
  logic [AW-1:0] addr_a, addr_b;
  logic          fwd_a, fwd_b, fwd_rd;
  logic [DW-1:0] opnd_a, opnd_b;
  logic          hazard, ready, accept;

  // scoreboard and ID/EX register
  logic [NREG-1:0] busy, busy_nxt;
  logic            ex_valid_q;
  logic [3:0]      ex_opcode_q;
  logic [AW-1:0]   ex_rd_q;
  logic            ex_wr_q;
  logic [DW-1:0]   ex_op1_q, ex_op2_q, ex_imm_q;

  assign op   = bus.instr[15:12];
  assign rd   = bus.instr[11:9];
  assign rs1  = bus.instr[8:6];
  assign rs2  = bus.instr[5:3];
  assign imm6 = bus.instr[5:0];

  // opcode class decode: which sources are read and whether rd is written
  always_comb begin
    use_a     = 1'b0;
    use_b     = 1'b0;
    rd_as_src = 1'b0;
    wr_cls    = 1'b0;
    case (op)
      4'h0:                         begin use_a = 1'b1; wr_cls = 1'b1; end
      4'h1, 4'hB:                   begin use_a = 1'b1; use_b = 1'b1; rd_as_src = 1'b1; end
      4'h2, 4'h3, 4'h4, 4'h5,
      4'h6, 4'h7, 4'h8, 4'h9:       begin use_a = 1'b1; use_b = 1'b1; wr_cls = 1'b1; end
      4'hA:                         begin use_a = 1'b1; wr_cls = 1'b1; end
      default:                      ;
    endcase
  end

  // port 2 reads rd for ST/BEQ (store data / compare operand), rs2 otherwise
  assign addr_a = rs1;
  assign addr_b = rd_as_src ? rd : rs2;
  assign bus.reg_read_addr_1 = addr_a;
  assign bus.reg_read_addr_2 = addr_b;

  // the file only updates at the edge, so same-cycle write-back data bypasses the read port
  assign fwd_a  = bus.wb_en && (bus.wb_dest == addr_a);
  assign fwd_b  = bus.wb_en && (bus.wb_dest == addr_b);
  assign fwd_rd = bus.wb_en && (bus.wb_dest == rd);
  assign opnd_a = fwd_a ? bus.wb_data : bus.reg_read_data_1;
  assign opnd_b = fwd_b ? bus.wb_data : bus.reg_read_data_2;

  // a busy source is fine only if its value arrives this cycle; a busy destination likewise (WAW)
  assign hazard = (use_a && busy[addr_a] && !fwd_a) ||
                  (use_b && busy[addr_b] && !fwd_b) ||
                  (wr_cls && busy[rd] && !fwd_rd);

  assign ready  = !hazard && (!ex_valid_q || bus.ex_ready) && !bus.flush;
  assign accept = bus.instr_valid && ready;
  assign bus.instr_ready = ready;

  // scoreboard update: write-back clears, squashed writer clears, accepted writer sets (set wins)
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en)
      busy_nxt[bus.wb_dest] = 1'b0;
    if (bus.flush && ex_valid_q && ex_wr_q)
      busy_nxt[ex_rd_q] = 1'b0;
    if (accept && wr_cls)
      busy_nxt[rd] = 1'b1;
  end

  // scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // ID/EX register: flush squashes, accept loads, consumed entry drains, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_imm_q    <= '0;
    end else if (bus.flush) begin
      ex_valid_q  <= 1'b0;
    end else if (accept) begin
      ex_valid_q  <= 1'b1;
      ex_opcode_q <= op;
      ex_rd_q     <= rd;
      ex_wr_q     <= wr_cls;
      ex_op1_q    <= opnd_a;
      ex_op2_q    <= opnd_b;
      ex_imm_q    <= {{(DW-6){imm6[5]}}, imm6};
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_opcode = ex_opcode_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_wr     = ex_wr_q;
  assign bus.ex_op1    = ex_op1_q;
  assign bus.ex_op2    = ex_op2_q;
  assign bus.ex_imm    = ex_imm_q;
endmodule
